// File: rtl/comp_scan_pkg.sv
// Shared types and helpers for the comparator scan controller.
// Build option: define COMP_DEBOUNCE_EN to insert a per-bit debouncer
// between the synchroniser and the bank snapshot.
package comp_scan_pkg;

  // Width of one comparator bank
  localparam int COMP_W = 5;

  // Widest bank vector the slicing helper accepts (banks beyond this are unsupported)
  localparam int MAX_BANKS = 32;

  // Scan sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  // Pick bank k out of a flattened, zero-padded vector of banks
  function automatic logic [COMP_W-1:0] bank_slice(
    input logic [COMP_W*MAX_BANKS-1:0] flat,
    input int                          k
  );
    return flat[k*COMP_W +: COMP_W];
  endfunction

endpackage

// File: rtl/comp_debounce.sv
// Single-bit debouncer: the accepted value only follows the input after the
// input has disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
// Instantiated only in builds with COMP_DEBOUNCE_EN defined.
module comp_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_reg;
  logic          dout_reg;

  // Count consecutive disagreeing cycles; flip the accepted value on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      dout_reg <= 1'b0;
    end else if (din == dout_reg) begin
      cnt_reg  <= '0;
    end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
      dout_reg <= din;
      cnt_reg  <= '0;
    end else begin
      cnt_reg  <= cnt_reg + 1'b1;
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/comp_scan_ctrl.sv
// Time-shares one comparator-count 7-segment decoder across NUM_DIGITS banks.
// Each bank is synchronised (2 flops), optionally debounced, then snapshotted.
// A SHOW/BLANK sequencer walks the banks; the bank word is presented on
// dec_comps one cycle before its digit enable goes active.
// Build option: define COMP_DEBOUNCE_EN to add comp_debounce on every bit.
module comp_scan_ctrl
  import comp_scan_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int SCAN_DIV        = 50000,
  parameter int BLANK_CYCLES    = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          hold,
  input  logic [NUM_DIGITS*COMP_W-1:0]  comps_in,
  output logic [COMP_W-1:0]             dec_comps,
  output logic [NUM_DIGITS-1:0]         dig_en_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int IW      = $clog2(NUM_DIGITS);
  localparam int BW      = NUM_DIGITS * COMP_W;
  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);

  // Parameter sanity: elaborates to nothing, but documents the legal ranges
  if (NUM_DIGITS > MAX_BANKS || DEBOUNCE_CYCLES < 1) begin : g_param_out_of_range
  end

  logic [BW-1:0]               sync1_reg;
  logic [BW-1:0]               sync2_reg;
  logic [BW-1:0]               filt;
  logic [BW-1:0]               snap_reg;
  logic [COMP_W*MAX_BANKS-1:0] snap_flat;

  scan_state_t     state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [IW-1:0]   idx_reg, idx_next;

  logic [COMP_W-1:0]     dec_comps_reg;
  logic [NUM_DIGITS-1:0] dig_en_n_reg;

  // Two-flop synchroniser on every comparator bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= comps_in;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef COMP_DEBOUNCE_EN
  // One debouncer per synchronised bit
  for (genvar gi = 0; gi < BW; gi++) begin : g_deb
    comp_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (sync2_reg[gi]),
      .dout (filt[gi])
    );
  end
`else
  assign filt = sync2_reg;
`endif

  // Snapshot follows the filtered inputs unless frozen by hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_reg <= '0;
    end else if (!hold) begin
      snap_reg <= filt;
    end
  end

  // Zero-pad the snapshot to the helper's fixed width
  always_comb begin
    snap_flat         = '0;
    snap_flat[BW-1:0] = snap_reg;
  end

  // Sequencer state, dwell counter and bank index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

  // Next-state: dropping enable always returns to IDLE at digit 0
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    if (!enable) begin
      state_next = IDLE;
      cnt_next   = '0;
      idx_next   = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          state_next = SHOW;
          cnt_next   = '0;
          idx_next   = '0;
        end
        SHOW: begin
          if (cnt_reg == CW'(SCAN_DIV - 1)) begin
            state_next = BLANK;
            cnt_next   = '0;
          end else begin
            cnt_next   = cnt_reg + 1'b1;
          end
        end
        BLANK: begin
          if (cnt_reg == CW'(BLANK_CYCLES - 1)) begin
            state_next = SHOW;
            cnt_next   = '0;
            idx_next   = (idx_reg == IW'(NUM_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
          end else begin
            cnt_next   = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          idx_next   = '0;
        end
      endcase
    end
  end

  // Output registers: dec_comps tracks the upcoming state, while the digit
  // enable tracks the current one, so segments settle a cycle before the
  // digit lights; enable=0 kills the digit on the very next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_comps_reg <= '0;
      dig_en_n_reg  <= '1;
    end else begin
      dec_comps_reg <= (state_next == IDLE) ? '0 : bank_slice(snap_flat, int'(idx_next));
      dig_en_n_reg  <= (enable && state_reg == SHOW) ?
                       ~(NUM_DIGITS'(1) << idx_reg) : '1;
    end
  end

  assign dec_comps = dec_comps_reg;
  assign dig_en_n  = dig_en_n_reg;
  assign digit_idx = idx_reg;

endmodule

// File: tb/tb_comp_scan_ctrl.sv
// Scoreboard bench for comp_scan_ctrl: stimulus pushes one expected entry per
// lit-digit cycle; a negedge monitor pops and compares whenever a digit is on,
// and also checks one-hot enables and the minimum blank gap.
module tb_comp_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BC = 2;
  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        hold = 1'b0;
  logic [19:0] comps_in = '0;
  logic [4:0]  dec_comps;
  logic [3:0]  dig_en_n;
  logic [1:0]  digit_idx;

  always #5 clk = ~clk;

  comp_scan_ctrl #(
    .NUM_DIGITS(ND),
    .SCAN_DIV(SD),
    .BLANK_CYCLES(BC),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .hold(hold),
    .comps_in(comps_in),
    .dec_comps(dec_comps),
    .dig_en_n(dig_en_n),
    .digit_idx(digit_idx)
  );

  typedef struct {
    int         idx;
    logic [4:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_digit(input int idx, input logic [4:0] val, input int n);
    exp_t e;
    e.idx = idx;
    e.val = val;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 300) begin
      step();
      budget++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d entries left, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: one line per lit-digit cycle
  int off_cnt  = 0;
  int prev_idx = 0;
  bit have_prev = 1'b0;
  bit prev_on   = 1'b0;

  always @(negedge clk) begin
    int   on_idx;
    exp_t e;
    if (!rst_n) begin
      have_prev = 1'b0;
      prev_on   = 1'b0;
      off_cnt   = 0;
    end else begin
      chk("onehot0", int'($onehot0(~dig_en_n)), 1);
      if (dig_en_n == 4'hF) begin
        off_cnt++;
        prev_on = 1'b0;
      end else begin
        on_idx = 0;
        for (int i = 0; i < ND; i++) if (!dig_en_n[i]) on_idx = i;
        if (prev_on && on_idx != prev_idx) begin
          n_checks++;
          n_fail++;
          $display("FAIL blank_gap: digit %0d followed digit %0d with 0 blank cycles, expected >= %0d",
                   on_idx, prev_idx, BC);
        end else if (!prev_on && have_prev) begin
          n_checks++;
          if (off_cnt < BC) begin
            n_fail++;
            $display("FAIL blank_gap: %0d blank cycles, expected >= %0d", off_cnt, BC);
          end
        end
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_digit: digit %0d lit with dec_comps %0h, expected dark",
                   on_idx, dec_comps);
        end else begin
          e = exp_q.pop_front();
          $display("digit %0d on: dec_comps=%0h digit_idx=%0d (exp digit %0d val %0h)",
                   on_idx, dec_comps, digit_idx, e.idx, e.val);
          chk("digit_sel", on_idx, e.idx);
          chk("digit_idx", int'(digit_idx), e.idx);
          chk("dec_comps", int'(dec_comps), int'(e.val));
        end
        have_prev = 1'b1;
        prev_on   = 1'b1;
        prev_idx  = on_idx;
        off_cnt   = 0;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("idle_dec_comps", int'(dec_comps), 0);
    chk("idle_dig_en_n", int'(dig_en_n), 'hF);
    chk("idle_digit_idx", int'(digit_idx), 0);

    // Scan order and wrap
    comps_in = {5'h1F, 5'h0F, 5'h03, 5'h01};
    repeat (10) step();
    push_digit(0, 5'h01, SD);
    push_digit(1, 5'h03, SD);
    push_digit(2, 5'h0F, SD);
    push_digit(3, 5'h1F, SD);
    push_digit(0, 5'h01, SD);
    enable = 1'b1;
    wait_empty("scan");

    // Hold freezes bank 0, release lets the new value through
    hold = 1'b1;
    comps_in[4:0] = 5'h00;
    push_digit(1, 5'h03, SD);
    push_digit(2, 5'h0F, SD);
    push_digit(3, 5'h1F, SD);
    push_digit(0, 5'h01, SD);
    wait_empty("hold");
    hold = 1'b0;
    push_digit(1, 5'h03, SD);
    push_digit(2, 5'h0F, SD);
    push_digit(3, 5'h1F, SD);
    push_digit(0, 5'h00, SD);
    wait_empty("release");

    // Enable drop in cycle 2 of digit 1
    push_digit(1, 5'h03, 2);
    wait_empty("partial");
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_dig_en_n", int'(dig_en_n), 'hF);
    chk("drop_dec_comps", int'(dec_comps), 0);
    chk("drop_digit_idx", int'(digit_idx), 0);
    repeat (2) step();
    push_digit(0, 5'h00, SD);
    push_digit(1, 5'h03, SD);
    enable = 1'b1;
    wait_empty("restart");

    // Asynchronous reset mid-cycle during a blank
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dec_comps", int'(dec_comps), 0);
    chk("arst_dig_en_n", int'(dig_en_n), 'hF);
    chk("arst_digit_idx", int'(digit_idx), 0);
    enable = 1'b0;
    step();
    rst_n = 1'b1;

`ifdef COMP_DEBOUNCE_EN
    // 3-clk glitch frozen by hold: debouncer must have ignored it
    repeat (10) step();
    comps_in[0] = 1'b1;
    repeat (3) step();
    comps_in[0] = 1'b0;
    hold = 1'b1;
    repeat (4) step();
    push_digit(0, 5'h00, SD);
    enable = 1'b1;
    wait_empty("glitch");
    enable = 1'b0;
    hold = 1'b0;
    // Steady level is accepted after the debounce window
    comps_in[0] = 1'b1;
    repeat (9) step();
    push_digit(0, 5'h01, SD);
    enable = 1'b1;
    wait_empty("level");
    enable = 1'b0;
    repeat (2) step();
`endif

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
